insertion_sort_engine: RTL and testbench
========================================

// Module: insertion_sort_engine
// PURPOSE
//  Self-contained in-place insertion sorter over a word-addressed memory slave with
//  separate read (AR/R) and write (AW/W/B) valid/ready channels. It merges sequencing,
//  datapath and write handling into one block with a run-time base address, length,
//  sort order and signedness. It sits between the user start/done interface and the memory.
// PARAMETERS
//  ADDR_WDTH  4   memory word-address width; max array length 2**ADDR_WDTH
//  DATA_WDTH  32  element width
//  RESP_WDTH  2   r_resp/b_resp width
//  OKAY_RESP  0   response code meaning success; any other value is an error
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  start        in   1            begin sort; sampled only in IDLE, DONE or ERR
//  base_addr    in   ADDR_WDTH    address of element 0; latched at start
//  arr_size     in   ADDR_WDTH+1  element count; latched at start
//  descending   in   1            1: sort descending, 0: ascending; latched at start
//  signed_cmp   in   1            1: two's-complement compare; latched at start
//  busy         out  1            high from the cycle after start until DONE/ERR
//  done         out  1            high in DONE (level); cleared by the next start
//  error        out  1            high in ERR (level); cleared by the next start
//  move_count   out  2*ADDR_WDTH  number of shift writes in the current/last run
//  ar_valid/ar_ready/ar_addr      out/in/out  1/1/ADDR_WDTH  read address channel
//  r_valid/r_ready                in/out      1/1            read data handshake
//  r_data/r_resp                  in          DATA_WDTH/RESP_WDTH
//  aw_valid/aw_ready/aw_addr      out/in/out  1/1/ADDR_WDTH  write address channel
//  w_valid/w_ready/w_data         out/in/out  1/1/DATA_WDTH  write data channel
//  b_valid/b_ready/b_resp         in/out/in   1/1/RESP_WDTH  write response channel
// BEHAVIOUR
//  Reset: state IDLE. All valids, readies, busy, done and error are 0.
//   move_count, addresses and data are 0. Reset mid-run aborts immediately; no partial
//   write is completed.
//  Algorithm: for i=1..n-1: key=A[i]; j=i-1; while j>=0: read A[j]. If A[j] is in order
//   w.r.t. key (asc: A[j]<=key, desc: A[j]>=key), break. Else write A[j+1]=A[j],
//   move_count++, j--. After the loop, write A[j+1]=key only if at least one shift occurred.
//   Equal keys never move (stable).
//  Address = base_addr + index, modulo 2**ADDR_WDTH (wrap is legal). i and j are
//   ADDR_WDTH+1 bits; j is signed, and j<0 ends the inner loop.
//  States: IDLE, OUTER_CHK, RD_KEY_A, RD_KEY_R, INNER_CHK, RD_CMP_A, RD_CMP_R, COMPARE,
//   WR_SHIFT_AW, WR_SHIFT_B, DEC_J, WR_KEY_AW, WR_KEY_B, INC_I, DONE, ERR.
//  IDLE/DONE/ERR + start -> OUTER_CHK: latch inputs, i=1, move_count=0, clear done/error.
//   arr_size > 2**ADDR_WDTH -> ERR instead.
//  OUTER_CHK: i<n -> RD_KEY_A, else DONE. So n=0 or 1 reaches DONE 2 cycles after start.
//  Read: ar_valid is high with a stable ar_addr until ar_ready; then r_ready is high
//   until r_valid. r_resp!=OKAY_RESP -> ERR, else capture r_data. RD_KEY_R -> INNER_CHK
//   with j=i-1. RD_CMP_R -> COMPARE.
//  Write: aw_valid and w_valid rise together. Each drops independently after its own
//   handshake (same-cycle acceptance is allowed). b_ready rises only after both are
//   accepted and holds until b_valid. b_resp!=OKAY_RESP -> ERR.
//  Only one transaction is outstanding at a time; read and write never overlap.
//  ERR: all valids/readies drop; error is held; the memory contents are undefined.
//  start is ignored while busy. A start in the same cycle as reset release is ignored.
// TESTING
//  1. n=4, base=2, asc, mem[2..5]={5,3,8,1} -> mem={1,3,5,8}, done=1, move_count=4.
//  2. n=4, desc, signed, {-1,7,-8,0} -> {7,0,-1,-8}; the same data unsigned asc ->
//      {0,7,0xFFFFFFF8,0xFFFFFFFF}.
//  3. n=0 and n=1 -> done 2 cycles after start, no AR/AW issued; n=17 (ADDR_WDTH=4)
//      -> error.
//  4. base=14, n=4, {4,3,2,1} -> addresses wrap 14,15,0,1; result {1,2,3,4},
//      move_count=6.
//  5. Random ar/aw/w/r/b ready-valid stalls (0-5 cycles), including aw/w accepted in
//      different cycles -> same result; valid and address stable while stalled.
//  6. b_resp=2 on the 2nd write -> ERR, error=1, busy=0; then a new start -> error=0 and
//      a normal completion. Also: rst_n low mid-read -> ar_valid=0 the same cycle.

Source files
------------

// File: rtl/insertion_sort_engine.sv
// In-place insertion sorter driving a word-addressed memory over split read/write
// valid/ready channels; one transaction outstanding at a time.
module insertion_sort_engine #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 2,
  parameter int OKAY_RESP = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WDTH-1:0]   base_addr,
  input  logic [ADDR_WDTH:0]     arr_size,
  input  logic                   descending,
  input  logic                   signed_cmp,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2*ADDR_WDTH-1:0] move_count,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  output logic [ADDR_WDTH-1:0]   ar_addr,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [DATA_WDTH-1:0]   r_data,
  input  logic [RESP_WDTH-1:0]   r_resp,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [ADDR_WDTH-1:0]   aw_addr,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [DATA_WDTH-1:0]   w_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [RESP_WDTH-1:0]   b_resp
);
  localparam int IW = ADDR_WDTH + 1;
  localparam logic [IW-1:0] MAX_LEN = {1'b1, {ADDR_WDTH{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, OUTER_CHK, RD_KEY_A, RD_KEY_R, INNER_CHK, RD_CMP_A, RD_CMP_R, COMPARE,
    WR_SHIFT_AW, WR_SHIFT_B, DEC_J, WR_KEY_AW, WR_KEY_B, INC_I, DONE, ERR
  } state_t;

  state_t                  state_reg, state_next;
  logic                    armed_reg;
  logic [IW-1:0]           i_reg, n_reg;
  logic signed [IW-1:0]    j_reg;
  logic [ADDR_WDTH-1:0]    base_reg;
  logic                    desc_reg, sgn_reg, shifted_reg;
  logic [DATA_WDTH-1:0]    key_reg, cmp_reg;
  logic                    aw_done_reg, w_done_reg;
  logic [2*ADDR_WDTH-1:0]  move_count_reg;

  logic rd_addr_phase, rd_data_phase, wr_addr_phase, wr_resp_phase;
  logic ar_fire, r_fire, aw_fire, w_fire, b_fire, wr_accepted;
  logic r_ok, b_ok, in_order, start_take, idle_like;

  assign idle_like     = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR);
  assign start_take    = idle_like && start && armed_reg;
  assign rd_addr_phase = (state_reg == RD_KEY_A) || (state_reg == RD_CMP_A);
  assign rd_data_phase = (state_reg == RD_KEY_R) || (state_reg == RD_CMP_R);
  assign wr_addr_phase = (state_reg == WR_SHIFT_AW) || (state_reg == WR_KEY_AW);
  assign wr_resp_phase = (state_reg == WR_SHIFT_B) || (state_reg == WR_KEY_B);

  assign ar_valid = rd_addr_phase;
  assign r_ready  = rd_data_phase;
  assign aw_valid = wr_addr_phase && !aw_done_reg;
  assign w_valid  = wr_addr_phase && !w_done_reg;
  assign b_ready  = wr_resp_phase;
  assign ar_addr  = (state_reg == RD_KEY_A) ? base_reg + i_reg[ADDR_WDTH-1:0] :
                    (state_reg == RD_CMP_A) ? base_reg + j_reg[ADDR_WDTH-1:0] : '0;
  // Both shift and key writes target slot j+1.
  assign aw_addr  = wr_addr_phase ? base_reg + j_reg[ADDR_WDTH-1:0] + ADDR_WDTH'(1) : '0;
  assign w_data   = (state_reg == WR_KEY_AW)   ? key_reg :
                    (state_reg == WR_SHIFT_AW) ? cmp_reg : '0;

  assign busy       = !idle_like;
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERR);
  assign move_count = move_count_reg;

  assign ar_fire     = ar_valid && ar_ready;
  assign r_fire      = r_ready && r_valid;
  assign aw_fire     = aw_valid && aw_ready;
  assign w_fire      = w_valid && w_ready;
  assign b_fire      = b_ready && b_valid;
  assign wr_accepted = (aw_done_reg || aw_fire) && (w_done_reg || w_fire);
  assign r_ok        = (r_resp == RESP_WDTH'(OKAY_RESP));
  assign b_ok        = (b_resp == RESP_WDTH'(OKAY_RESP));

  always_comb begin
    in_order = 1'b0;
    if (sgn_reg)
      in_order = desc_reg ? ($signed(cmp_reg) >= $signed(key_reg))
                          : ($signed(cmp_reg) <= $signed(key_reg));
    else
      in_order = desc_reg ? (cmp_reg >= key_reg) : (cmp_reg <= key_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR:
        if (start_take) state_next = (arr_size > MAX_LEN) ? ERR : OUTER_CHK;
      OUTER_CHK:   state_next = (i_reg < n_reg) ? RD_KEY_A : DONE;
      RD_KEY_A:    if (ar_fire) state_next = RD_KEY_R;
      RD_KEY_R:    if (r_fire) state_next = r_ok ? INNER_CHK : ERR;
      INNER_CHK: begin
        if (j_reg[IW-1]) state_next = shifted_reg ? WR_KEY_AW : INC_I;
        else             state_next = RD_CMP_A;
      end
      RD_CMP_A:    if (ar_fire) state_next = RD_CMP_R;
      RD_CMP_R:    if (r_fire) state_next = r_ok ? COMPARE : ERR;
      COMPARE: begin
        if (in_order) state_next = shifted_reg ? WR_KEY_AW : INC_I;
        else          state_next = WR_SHIFT_AW;
      end
      WR_SHIFT_AW: if (wr_accepted) state_next = WR_SHIFT_B;
      WR_SHIFT_B:  if (b_fire) state_next = b_ok ? DEC_J : ERR;
      DEC_J:       state_next = INNER_CHK;
      WR_KEY_AW:   if (wr_accepted) state_next = WR_KEY_B;
      WR_KEY_B:    if (b_fire) state_next = b_ok ? INC_I : ERR;
      INC_I:       state_next = OUTER_CHK;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg      <= 1'b0;
      i_reg          <= '0;
      n_reg          <= '0;
      j_reg          <= '0;
      base_reg       <= '0;
      desc_reg       <= 1'b0;
      sgn_reg        <= 1'b0;
      shifted_reg    <= 1'b0;
      key_reg        <= '0;
      cmp_reg        <= '0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      move_count_reg <= '0;
    end else begin
      // Blocks a start that coincides with the first edge after reset release.
      armed_reg <= 1'b1;
      if (start_take) begin
        base_reg       <= base_addr;
        n_reg          <= arr_size;
        desc_reg       <= descending;
        sgn_reg        <= signed_cmp;
        i_reg          <= IW'(1);
        move_count_reg <= '0;
      end
      case (state_reg)
        RD_KEY_R: if (r_fire && r_ok) begin
          key_reg     <= r_data;
          j_reg       <= $signed(i_reg - IW'(1));
          shifted_reg <= 1'b0;
        end
        RD_CMP_R: if (r_fire && r_ok) cmp_reg <= r_data;
        WR_SHIFT_AW, WR_KEY_AW: begin
          if (wr_accepted) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
          end else begin
            if (aw_fire) aw_done_reg <= 1'b1;
            if (w_fire)  w_done_reg  <= 1'b1;
          end
        end
        WR_SHIFT_B: if (b_fire && b_ok) begin
          move_count_reg <= move_count_reg + 1'b1;
          shifted_reg    <= 1'b1;
        end
        DEC_J:   j_reg <= j_reg - IW'(1);
        INC_I:   i_reg <= i_reg + IW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_insertion_sort_engine.sv
// Bench for insertion_sort_engine: randomly stalling memory slave, sort model and
// scoreboard of expected memory images and move counts.
module tb_insertion_sort_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  arr_size;
  logic        descending, signed_cmp;
  logic        busy, done, error;
  logic [7:0]  move_count;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  ar_addr, aw_addr;
  logic [31:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;

  always #5 clk = ~clk;

  insertion_sort_engine #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(2), .OKAY_RESP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .arr_size(arr_size),
    .descending(descending), .signed_cmp(signed_cmp), .busy(busy), .done(done),
    .error(error), .move_count(move_count),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  int tests, fails;
  int stall_max, err_at;
  int wr_total = 0, ar_total = 0, aw_total = 0, viol = 0, pv;
  logic [31:0] mem [16];
  logic [31:0] load_img [16];
  logic [31:0] vals [16];
  logic        load_req;
  logic [31:0] exp_q [$];
  int          mc_q [$];

  // Memory slave state
  logic        rd_pend, aw_got, w_got, b_pend;
  logic [3:0]  rd_addr, wa;
  logic [31:0] wd;
  int          rd_cnt, b_cnt;
  logic        p_ar_stall, p_aw_stall, p_w_stall;
  logic [3:0]  p_ar_addr, p_aw_addr;
  logic [31:0] p_w_data;

  function automatic logic rnd_ready();
    return (stall_max == 0) || ($urandom_range(0, stall_max) == 0);
  endfunction
  function automatic int rnd_delay();
    return (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_ready <= 0; aw_ready <= 0; w_ready <= 0; r_valid <= 0; b_valid <= 0;
      r_data <= 0; r_resp <= 0; b_resp <= 0;
      rd_pend <= 0; aw_got <= 0; w_got <= 0; b_pend <= 0; rd_cnt <= 0; b_cnt <= 0;
      rd_addr <= 0; wa <= 0; wd <= 0;
      p_ar_stall <= 0; p_aw_stall <= 0; p_w_stall <= 0;
      p_ar_addr <= 0; p_aw_addr <= 0; p_w_data <= 0;
    end else begin
      if (load_req) for (int k = 0; k < 16; k++) mem[k] <= load_img[k];
      ar_ready <= rnd_ready();
      aw_ready <= rnd_ready();
      w_ready  <= rnd_ready();
      if (ar_valid && ar_ready) begin
        rd_pend <= 1; rd_addr <= ar_addr; rd_cnt <= rnd_delay(); ar_total <= ar_total + 1;
      end
      if (rd_pend && !r_valid) begin
        if (rd_cnt == 0) begin r_valid <= 1; r_data <= mem[rd_addr]; r_resp <= 0; end
        else rd_cnt <= rd_cnt - 1;
      end
      if (r_valid && r_ready) begin r_valid <= 0; rd_pend <= 0; end
      if (aw_valid && aw_ready) begin aw_got <= 1; wa <= aw_addr; aw_total <= aw_total + 1; end
      if (w_valid && w_ready) begin w_got <= 1; wd <= w_data; end
      if (aw_got && w_got && !b_pend) begin
        mem[wa] <= wd; b_pend <= 1; b_cnt <= rnd_delay(); aw_got <= 0; w_got <= 0;
      end
      if (b_pend && !b_valid) begin
        if (b_cnt == 0) begin
          b_valid <= 1; b_resp <= (wr_total + 1 == err_at) ? 2'd2 : 2'd0;
          wr_total <= wr_total + 1;
        end else b_cnt <= b_cnt - 1;
      end
      if (b_valid && b_ready) begin b_valid <= 0; b_pend <= 0; end
      // Protocol watch: stalled valids keep their payload; reads and writes never overlap.
      pv = 0;
      if (p_ar_stall && (!ar_valid || ar_addr != p_ar_addr)) pv++;
      if (p_aw_stall && (!aw_valid || aw_addr != p_aw_addr)) pv++;
      if (p_w_stall && (!w_valid || w_data != p_w_data)) pv++;
      if ((ar_valid || r_ready) && (aw_valid || w_valid || b_ready)) pv++;
      viol <= viol + pv;
      p_ar_stall <= ar_valid && !ar_ready; p_ar_addr <= ar_addr;
      p_aw_stall <= aw_valid && !aw_ready; p_aw_addr <= aw_addr;
      p_w_stall  <= w_valid && !w_ready;   p_w_data  <= w_data;
    end
  end

  function automatic bit out_of(input logic [31:0] a, input logic [31:0] b, input bit d, input bit s);
    bit gt_ab, gt_ba;
    gt_ab = s ? ($signed(a) > $signed(b)) : (a > b);
    gt_ba = s ? ($signed(b) > $signed(a)) : (b > a);
    return d ? gt_ba : gt_ab;
  endfunction

  task automatic load_mem(input logic [3:0] b, input int n);
    for (int k = 0; k < 16; k++) load_img[k] = 32'hA5A5_0000 | k;
    for (int k = 0; k < n && k < 16; k++) load_img[(int'(b) + k) % 16] = vals[k];
    @(negedge clk); load_req = 1;
    @(posedge clk); #1 load_req = 0;
  endtask

  task automatic start_run(input logic [3:0] b, input logic [4:0] n, input logic d, input logic s);
    @(negedge clk);
    base_addr = b; arr_size = n; descending = d; signed_cmp = s; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_end(input string name, output bit ok);
    int c = 0;
    while (done !== 1'b1 && error !== 1'b1 && c < 20000) begin @(posedge clk); #1; c++; end
    ok = (done === 1'b1 || error === 1'b1);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy=%b done=%b error=%b, required done or error", name, busy, done, error);
    end
  endtask

  task automatic run_sort(input string name, input logic [3:0] b, input int n, input bit d, input bit s);
    logic [31:0] img [16];
    logic [31:0] sl [16];
    logic [31:0] t;
    int mv, em, bad;
    bit ok;
    load_mem(b, n);
    for (int k = 0; k < 16; k++) img[k] = load_img[k];
    for (int k = 0; k < n; k++) sl[k] = vals[k];
    mv = 0;
    for (int p = 0; p < n; p++)
      for (int q = p + 1; q < n; q++) if (out_of(sl[p], sl[q], d, s)) mv++;
    for (int p = 0; p < n - 1; p++)
      for (int q = 0; q < n - 1 - p; q++)
        if (out_of(sl[q], sl[q+1], d, s)) begin t = sl[q]; sl[q] = sl[q+1]; sl[q+1] = t; end
    for (int k = 0; k < n; k++) img[(int'(b) + k) % 16] = sl[k];
    for (int k = 0; k < 16; k++) exp_q.push_back(img[k]);
    mc_q.push_back(mv);
    start_run(b, 5'(n), d, s);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL %s_start: busy/done/error=%b%b%b required 100", name, busy, done, error);
    end
    wait_end(name, ok);
    bad = 0;
    if (ok) begin
      tests++;
      if (done !== 1'b1 || error !== 1'b0) begin
        fails++; $display("FAIL %s_status: done=%b error=%b required done=1 error=0", name, done, error);
      end
      for (int k = 0; k < 16; k++) begin
        t = exp_q.pop_front();
        tests++;
        if (mem[k] !== t) begin
          fails++; bad++;
          $display("FAIL %s_mem[%0d]: got %h required %h", name, k, mem[k], t);
        end
      end
      em = mc_q.pop_front();
      tests++;
      if (move_count !== 8'(em)) begin
        fails++; $display("FAIL %s_moves: got %0d required %0d", name, move_count, em);
      end
    end else begin
      for (int k = 0; k < 16; k++) void'(exp_q.pop_front());
      void'(mc_q.pop_front());
    end
    $display("[TB] %s: base=%0d n=%0d desc=%0d signed=%0d moves=%0d word_errors=%0d",
             name, b, n, d, s, move_count, bad);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, error, ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 8'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 00000000",
                        {busy, done, error, ar_valid, r_ready, aw_valid, w_valid, b_ready});
    end
    tests++;
    if (move_count !== 8'd0 || ar_addr !== 4'd0 || aw_addr !== 4'd0 || w_data !== 32'd0) begin
      fails++; $display("FAIL reset_data: moves=%0d ar=%0d aw=%0d w=%h required all 0",
                        move_count, ar_addr, aw_addr, w_data);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    $display("[TB] reset: busy=%b done=%b error=%b", busy, done, error);
  endtask

  task automatic test_basic();
    vals[0] = 5; vals[1] = 3; vals[2] = 8; vals[3] = 1;
    run_sort("basic_asc", 4'd2, 4, 0, 0);
  endtask

  task automatic test_signed();
    vals[0] = 32'hFFFF_FFFF; vals[1] = 7; vals[2] = 32'hFFFF_FFF8; vals[3] = 0;
    run_sort("desc_signed", 4'd0, 4, 1, 1);
    vals[0] = 32'hFFFF_FFFF; vals[1] = 7; vals[2] = 32'hFFFF_FFF8; vals[3] = 0;
    run_sort("asc_unsigned", 4'd0, 4, 0, 0);
  endtask

  task automatic test_small();
    int a0, w0;
    for (int n = 0; n < 2; n++) begin
      vals[0] = 9;
      load_mem(4'd3, n);
      a0 = ar_total; w0 = aw_total;
      start_run(4'd3, 5'(n), 0, 0);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL small%0d_cycle1: busy=%b done=%b required 1 0", n, busy, done);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        fails++; $display("FAIL small%0d_cycle2: done=%b busy=%b required 1 0", n, done, busy);
      end
      tests++;
      if (ar_total != a0 || aw_total != w0 || move_count !== 8'd0) begin
        fails++; $display("FAIL small%0d_traffic: ar=%0d aw=%0d moves=%0d required 0 0 0",
                          n, ar_total - a0, aw_total - w0, move_count);
      end
      $display("[TB] small n=%0d: done=%b", n, done);
    end
  endtask

  task automatic test_oversize();
    start_run(4'd0, 5'd17, 0, 0);
    tests++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL oversize: error/busy/done=%b%b%b required 100", error, busy, done);
    end
    $display("[TB] oversize n=17: error=%b", error);
  endtask

  task automatic test_wrap();
    vals[0] = 4; vals[1] = 3; vals[2] = 2; vals[3] = 1;
    run_sort("wrap", 4'd14, 4, 0, 0);
  endtask

  task automatic test_back_to_back();
    int v0, n;
    v0 = viol;
    stall_max = 5;
    vals[0] = 5; vals[1] = 3; vals[2] = 8; vals[3] = 1;
    run_sort("stall_basic", 4'd2, 4, 0, 0);
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(2, 16));
      for (int k = 0; k < 16; k++) vals[k] = (r % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      run_sort("stall_rand", 4'($urandom_range(0, 15)), n, bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)));
    end
    stall_max = 0;
    tests++;
    if (viol != v0) begin
      fails++; $display("FAIL protocol: %0d violations required 0", viol - v0);
    end
  endtask

  task automatic test_error();
    bit ok;
    vals[0] = 5; vals[1] = 3; vals[2] = 8; vals[3] = 1;
    load_mem(4'd2, 4);
    err_at = wr_total + 2;
    start_run(4'd2, 5'd4, 0, 0);
    wait_end("bresp_err", ok);
    if (ok) begin
      tests++;
      if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL bresp_err: error/done/busy=%b%b%b required 100", error, done, busy);
      end
      tests++;
      if ({ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 5'b0) begin
        fails++; $display("FAIL bresp_err_idle: handshakes=%b required 00000",
                          {ar_valid, r_ready, aw_valid, w_valid, b_ready});
      end
    end
    $display("[TB] bresp_err: error=%b busy=%b", error, busy);
    err_at = 0;
    vals[0] = 5; vals[1] = 3; vals[2] = 8; vals[3] = 1;
    run_sort("after_err", 4'd2, 4, 0, 0);
  endtask

  task automatic test_reset_mid();
    int c = 0;
    vals[0] = 5; vals[1] = 3; vals[2] = 8; vals[3] = 1;
    load_mem(4'd2, 4);
    stall_max = 2;
    start_run(4'd2, 5'd4, 0, 0);
    while (ar_valid !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    tests++;
    if (ar_valid !== 1'b1) begin
      fails++; $display("FAIL midrst_read: ar_valid=%b required 1", ar_valid);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({ar_valid, busy, r_ready, aw_valid, w_valid} !== 5'b0) begin
      fails++; $display("FAIL midrst_abort: ar/busy/r/aw/w=%b required 00000",
                        {ar_valid, busy, r_ready, aw_valid, w_valid});
    end
    stall_max = 0;
    @(negedge clk);
    rst_n = 1; start = 1; base_addr = 2; arr_size = 4; descending = 0; signed_cmp = 0;
    @(posedge clk); #1;
    start = 0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL release_start: busy=%b done=%b required 0 0", busy, done);
    end
    $display("[TB] midrst: ar_valid=%b busy=%b", ar_valid, busy);
    vals[0] = 5; vals[1] = 3; vals[2] = 8; vals[3] = 1;
    run_sort("after_reset", 4'd2, 4, 0, 0);
  endtask

  initial begin
    tests = 0; fails = 0; stall_max = 0; err_at = 0; load_req = 0;
    start = 0; base_addr = 0; arr_size = 0; descending = 0; signed_cmp = 0; rst_n = 0;
    for (int k = 0; k < 16; k++) vals[k] = 0;
    test_reset();
    test_basic();
    test_signed();
    test_small();
    test_oversize();
    test_wrap();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
